dma_line_writer: RTL and testbench
==================================

Name: dma_line_writer

Overview:
DMA transfer engine between the external device and data memory. Accepts a base-address command from the CPU, requests the data bus (BR/BG handshake), then writes NUM_LINES 64-bit lines from the external device into consecutive memory locations. It drives the device's line-select offset and pulses an end-of-transfer interrupt to the CPU. It sits directly downstream of the CPU's DMA command output and upstream of data memory.

Parameters:
WORD_SIZE, 16, address and word width
LINE_WORDS, 4, words per line; line width is LINE_WORDS*WORD_SIZE
NUM_LINES, 3, lines per transfer (12 words total)
WRITE_CYCLES, 4, cycles the memory write strobe is held per line

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  CPU presents a DMA command this cycle
cmd  in  WORD_SIZE  destination base address
cmd_ready  out  1  engine idle; command accepted when cmd_valid&cmd_ready
BG  in  1  bus grant from CPU
BR  out  1  bus request to CPU
edata  in  LINE_WORDS*WORD_SIZE  line from external device, selected by offset
offset  out  2  line index presented to the external device
write_en  out  1  memory write strobe
addr  out  WORD_SIZE  memory line address
data_out  out  LINE_WORDS*WORD_SIZE  write data; tristate is resolved outside the block
data_oe  out  1  data_out drive enable (equals write_en)
interrupt  out  1  one-cycle end-of-transfer pulse
busy  out  1  high in any state other than IDLE

Behaviour:
- States are IDLE, REQ, XFER and DONE. All outputs are registered.
- Reset values: state IDLE, BR=0, write_en=0, data_oe=0, interrupt=0, offset=0, addr=0, data_out=0, cmd_ready=1, busy=0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at edge N: latch base=cmd, offset=0, go to REQ. BR=1 and busy=1 are visible after edge N.
- REQ:
  - BR=1 and write_en=0.
  - When BG=1 is sampled: go to XFER, cnt=0.
  - BG already high on entry is accepted in the first REQ cycle.
- XFER:
  - BR=1, write_en=1, data_oe=1.
  - addr = base + offset*LINE_WORDS, truncated to WORD_SIZE (16-bit wrap).
  - data_out = edata, sampled each cycle.
  - cnt increments each cycle.
  - At cnt==WRITE_CYCLES-1: if offset==NUM_LINES-1, go to DONE; otherwise offset+1, cnt=0 and stay in XFER. Lines are back-to-back with no gap cycle.
- BG drops during XFER (sampled 0):
  - Abort the current line immediately: write_en and data_oe are 0 after that edge.
  - Go to REQ with BR held at 1, keeping offset and resetting cnt=0.
  - The same line restarts in full when BG returns.
- DONE:
  - BR=0, write_en=0, interrupt=1 for exactly one cycle.
  - Next state is IDLE, with interrupt=0 and cmd_ready=1.
- Commands:
  - cmd_valid while busy is ignored and never queued; cmd_ready=0.
  - A command in the same cycle DONE returns to IDLE is ignored; cmd_ready is still 0 that cycle.
- BG=1 while BR=0 has no effect.
- Reset mid-transfer: return to IDLE and drop BR and write_en next edge. No interrupt is issued; the partial transfer is lost.
- Nominal latency with BG granted one cycle after BR: 1 (REQ) + NUM_LINES*WRITE_CYCLES (XFER) + 1 (DONE) cycles after acceptance.

Decomposition:
- Shared package dma_pkg holds:
  - state encoding (2-bit: IDLE, REQ, XFER, DONE)
  - WORD_SIZE and LINE_SIZE constants
  - an address-of-line helper function (base + offset*LINE_WORDS, 16-bit wrap)
- No sub-module is needed; the cycle counter and line counter stay inline.

Test Plan:
- Basic transfer: cmd=0x01F4, BG raised 2 cycles after BR. Required response: addr 0x01F4, 0x01F8, 0x01FC, each held for 4 write_en cycles; offset steps 0, 1, 2; data_out matches edata per offset; one interrupt pulse; BR low in the same cycle as the interrupt.
- Grant withdrawal: BG dropped on cycle 2 of line 1, then restored 3 cycles later. Required response: write_en low the next cycle; BR stays 1; line 1 (addr base+4) is rewritten for a full 4 cycles; total write_en cycles = 14.
- Busy command: a second cmd_valid (cmd=0x0300) during XFER. Required response: ignored, cmd_ready=0; only the 0x01F4 lines are written; one interrupt.
- Address wrap: cmd=0xFFFC. Required response: addr 0xFFFC, 0x0000, 0x0004.
- Reset mid-transfer: reset asserted during line 1. Required response: the next edge gives BR=0, write_en=0, busy=0, cmd_ready=1; no interrupt; a fresh command then completes normally.
- Spurious grant: BG=1 while IDLE with no command. Required response: BR, write_en and interrupt all remain 0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA line writer: state encoding, bus widths
// and the line-address helper.
package dma_pkg;

  localparam int WORD_SIZE        = 16;
  localparam int LINE_WORDS       = 4;
  localparam int LINE_SIZE        = LINE_WORDS * WORD_SIZE;
  localparam int DEF_NUM_LINES    = 3;
  localparam int DEF_WRITE_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } dma_state_e;

  // Memory address of line 'off' in a transfer starting at 'base'; wraps at 16 bits.
  function automatic logic [WORD_SIZE-1:0] line_addr(input logic [WORD_SIZE-1:0] base,
                                                     input logic [1:0]           off);
    return base + {{(WORD_SIZE-2){1'b0}}, off} * WORD_SIZE'(LINE_WORDS);
  endfunction

endpackage

// File: rtl/dma_line_writer.sv
// DMA engine: takes a base address from the CPU, requests the bus, then writes
// NUM_LINES device lines into consecutive memory lines and pulses an interrupt.
module dma_line_writer
  import dma_pkg::*;
#(
  parameter int NUM_LINES    = DEF_NUM_LINES,
  parameter int WRITE_CYCLES = DEF_WRITE_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  // Command handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready is only high in IDLE and nothing is queued.
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] cmd,
  output logic                 cmd_ready,
  input  logic                 BG,
  output logic                 BR,
  input  logic [LINE_SIZE-1:0] edata,
  output logic [1:0]           offset,
  output logic                 write_en,
  output logic [WORD_SIZE-1:0] addr,
  output logic [LINE_SIZE-1:0] data_out,
  output logic                 data_oe,
  output logic                 interrupt,
  output logic                 busy,
  output dma_state_e           state_dbg
);

  localparam int CNT_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [1:0]       LINE_LAST = 2'(NUM_LINES - 1);

  dma_state_e           state_q, state_d;
  logic [WORD_SIZE-1:0] base_q, base_d;
  logic [1:0]           offset_q, offset_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 br_q, br_d;
  logic                 we_q, we_d;
  logic                 int_q, int_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [LINE_SIZE-1:0] dout_q, dout_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      offset_q <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      we_q     <= 1'b0;
      int_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      we_q     <= we_d;
      int_q    <= int_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    we_d     = we_q;
    int_d    = int_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    dout_d   = dout_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d  = REQ;
          base_d   = cmd;
          offset_d = '0;
          br_d     = 1'b1;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
        end
      end
      REQ: begin
        if (BG) begin
          state_d = XFER;
          cnt_d   = '0;
          we_d    = 1'b1;
          addr_d  = line_addr(base_q, offset_q);
          dout_d  = edata;
        end
      end
      XFER: begin
        // A withdrawn grant aborts the line even on its last cycle; it restarts in full.
        if (!BG) begin
          state_d = REQ;
          cnt_d   = '0;
          we_d    = 1'b0;
        end else begin
          dout_d = edata;
          if (cnt_q == CNT_LAST) begin
            if (offset_q == LINE_LAST) begin
              state_d = DONE;
              br_d    = 1'b0;
              we_d    = 1'b0;
              int_d   = 1'b1;
            end else begin
              offset_d = offset_q + 2'd1;
              cnt_d    = '0;
              addr_d   = line_addr(base_q, offset_q + 2'd1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        int_d   = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = ready_q;
  assign BR        = br_q;
  assign offset    = offset_q;
  assign write_en  = we_q;
  assign data_oe   = we_q;
  assign addr      = addr_q;
  assign data_out  = dout_q;
  assign interrupt = int_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dma_line_writer.sv
// Bench for dma_line_writer: directed and randomized transfers checked against a
// transaction-level model of the expected write bursts and interrupt timing.
module tb_dma_line_writer;
  import dma_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cmd_valid;
  logic [WORD_SIZE-1:0] cmd;
  logic                 cmd_ready;
  logic                 BG;
  logic                 BR;
  logic [LINE_SIZE-1:0] edata;
  logic [1:0]           offset;
  logic                 write_en;
  logic [WORD_SIZE-1:0] addr;
  logic [LINE_SIZE-1:0] data_out;
  logic                 data_oe;
  logic                 interrupt;
  logic                 busy;
  dma_state_e           state_dbg;

  logic [LINE_SIZE-1:0] line_data [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External device: presents the line chosen by offset.
  assign edata = line_data[offset];

  dma_line_writer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .BG        (BG),
    .BR        (BR),
    .edata     (edata),
    .offset    (offset),
    .write_en  (write_en),
    .addr      (addr),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .interrupt (interrupt),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_lines();
    for (int i = 0; i < 3; i++) line_data[i] = {$urandom, $urandom};
    line_data[3] = '0;
  endtask

  // g: first REQ cycle index where BG is high. A drop holds BG low for drop_len
  // edges starting at the end of write cycle drop_cycle (1-based) of drop_line.
  task automatic run_transfer(input logic [15:0] base, input int g, input bit do_drop,
                              input int drop_line, input int drop_cycle, input int drop_len,
                              input int busy_cmd_at);
    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];
    logic [15:0] a;
    logic [15:0] run_addr;
    logic [15:0] rel;
    int run_len;
    bit in_run;
    bit seen_int;
    int ds, int_at, cyc, total_exp, total_obs;

    fill_lines();
    for (int k = 0; k < 3; k++) begin
      a = base + 16'(4 * k);
      if (do_drop && k == drop_line) exp_q.push_back({a, 8'(drop_cycle)});
      exp_q.push_back({a, 8'd4});
    end
    ds        = g + 1 + 4 * drop_line + drop_cycle - 1;
    int_at    = g + 13 + (do_drop ? drop_cycle + drop_len : 0);
    total_exp = 12 + (do_drop ? drop_cycle : 0);

    check("idle_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    cmd_valid = 1'b1;
    cmd       = base;
    BG        = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("accept_br", BR, 1);
    check("accept_busy", busy, 1);
    check("accept_ready", cmd_ready, 0);

    cyc = 0; seen_int = 0; in_run = 0; run_len = 0; run_addr = '0;
    while (cyc < 200 && !seen_int) begin
      check("oe_eq_we", data_oe, write_en);
      if (interrupt) begin
        seen_int = 1;
        check("int_cycle", 64'(cyc), 64'(int_at));
        check("done_br", BR, 0);
        check("done_we", write_en, 0);
      end else begin
        check("xfer_br", BR, 1);
        check("xfer_busy", busy, 1);
        check("xfer_ready", cmd_ready, 0);
      end
      if (write_en) begin
        rel = addr - base;
        check("offset_vs_addr", offset, 2'(rel >> 2));
        if (in_run && addr == run_addr) begin
          run_len++;
          check("data_out", data_out, line_data[2'(rel >> 2)]);
        end else begin
          if (in_run) obs_q.push_back({run_addr, 8'(run_len)});
          in_run = 1; run_addr = addr; run_len = 1;
        end
      end else if (in_run) begin
        obs_q.push_back({run_addr, 8'(run_len)});
        in_run = 0;
      end
      if (!seen_int) begin
        BG        = (cyc >= g) && !(do_drop && cyc >= ds && cyc < ds + drop_len);
        cmd_valid = (cyc == busy_cmd_at);
        cmd       = 16'h0300;
        tick();
        cmd_valid = 1'b0;
        cyc++;
      end
    end
    if (!seen_int) check("int_timeout", 0, 1);
    if (in_run) obs_q.push_back({run_addr, 8'(run_len)});

    // Command presented in the DONE cycle must be dropped.
    check("done_ready", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd       = 16'h0300;
    BG        = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("post_int", interrupt, 0);
    check("post_ready", cmd_ready, 1);
    check("post_busy", busy, 0);
    tick();
    check("done_cmd_ignored_busy", busy, 0);
    check("done_cmd_ignored_br", BR, 0);

    check("run_count", 64'(obs_q.size()), 64'(exp_q.size()));
    total_obs = 0;
    foreach (obs_q[i]) total_obs += int'(obs_q[i][7:0]);
    check("write_cycles", 64'(total_obs), 64'(total_exp));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check("run_addr_len", obs_q[i], exp_q[i]);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd = '0; BG = 1'b0;
    fill_lines();
    repeat (3) tick();
    check("rst_state", state_dbg, IDLE);
    check("rst_br", BR, 0);
    check("rst_we", write_en, 0);
    check("rst_oe", data_oe, 0);
    check("rst_int", interrupt, 0);
    check("rst_offset", offset, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data_out, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // Spurious grant while idle.
    BG = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("spur_br", BR, 0);
      check("spur_we", write_en, 0);
      check("spur_int", interrupt, 0);
    end
    BG = 1'b0;
    tick();

    run_transfer(16'h01F4, 2, 0, 0, 0, 0, -1);
    run_transfer(16'h01F4, 1, 1, 1, 2, 3, -1);
    run_transfer(16'h01F4, 0, 0, 0, 0, 0, 6);
    run_transfer(16'hFFFC, 1, 0, 0, 0, 0, -1);

    // Reset in the middle of line 1.
    fill_lines();
    cmd_valid = 1'b1; cmd = 16'h1000; BG = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !(write_en && addr == 16'h1004); i++) tick();
    check("mid_line1_reached", addr, 16'h1004);
    reset = 1'b1;
    tick();
    reset = 1'b0; BG = 1'b0;
    check("mid_rst_br", BR, 0);
    check("mid_rst_we", write_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_rst_no_int", interrupt, 0);
      check("mid_rst_idle", busy, 0);
    end
    run_transfer(16'h2220, 0, 0, 0, 0, 0, -1);

    for (int n = 0; n < 8; n++) begin
      run_transfer(16'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                   int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                   int'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
